// File: rtl/lsu_dmem_master.sv
// Load/store master for a word-addressed data memory: byte/half/word accesses,
// sign/zero-extended loads, read-modify-write sub-word stores, alignment/range errors.
module lsu_dmem_master #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, ACCESS, WRITE, RESP, ERR} state_t;
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nx;
  req_t        rq;
  logic [31:0] data_q, data_nx;
  logic        bad;
  logic        word_st;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic [NUM_LANES-1:0][7:0] merged;

  always_comb begin
    bad = (req_size == 2'b11) ||
          (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
          ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  end

  // Store merge: each lane keeps the memory byte unless it is addressed by the store.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int HB = i % 2;
    logic sel;
    always_comb begin
      sel = (rq.size == 2'b00) ? (rq.addr[1:0] == 2'(i)) : (rq.addr[1] == 1'(i / 2));
      merged[i] = sel ? ((rq.size == 2'b00) ? rq.wdata[7:0] : rq.wdata[8*HB +: 8])
                      : mem_rd[8*i +: 8];
    end
  end

  always_comb begin
    ld_b = mem_rd[8*rq.addr[1:0] +: 8];
    ld_h = rq.addr[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (rq.size)
      2'b00:   ld_ext = rq.uns ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_ext = rq.uns ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld_ext = mem_rd;
    endcase
  end

  assign word_st = rq.we && (rq.size == 2'b10);

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    case (state)
      IDLE:   if (req_valid) state_nx = bad ? ERR : ACCESS;
      ACCESS: begin
        if (!rq.we) begin
          data_nx  = ld_ext;
          state_nx = RESP;
        end else if (word_st) begin
          state_nx = RESP;
        end else begin
          data_nx  = merged;
          state_nx = WRITE;
        end
      end
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rq     <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
      if (state == IDLE && req_valid)
        rq <= '{we: req_we, size: req_size, uns: req_unsigned, addr: req_addr, wdata: req_wdata};
    end
  end

  // Outputs decode from state only, so reset clears them (mem_we included) asynchronously.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP) || (state == ERR);
    resp_err   = (state == ERR);
    resp_rdata = (state == RESP && !rq.we) ? data_q : 32'h0;
    mem_we     = (state == WRITE) || (state == ACCESS && word_st);
    mem_a      = (state == ACCESS || state == WRITE) ? {2'b00, rq.addr[31:2]} : 32'h0;
    mem_wd     = (state == WRITE) ? data_q :
                 (state == ACCESS && word_st) ? rq.wdata : 32'h0;
  end
endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: directed loads/stores/errors, back-to-back, reset abort.
module tb_lsu_dmem_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwe;
    logic [31:0] wd;
    int          acc;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0, cyc = 0, we_cnt = 0;
  logic [31:0] last_wd = 0;

  lsu_dmem_master #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : 32'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_a[5:0]] <= mem_wd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts write cycles and checks each response against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_we) begin
        we_cnt++;
        last_wd = mem_wd;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_resp: got resp_valid with no request outstanding");
        end else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          chk("we_cycles", 32'(we_cnt), 32'(e.nwe));
          if (e.nwe > 0) chk("mem_wd", last_wd, e.wd);
        end
        we_cnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input int lat,
                       input int nwe, input logic [31:0] wd, input bit hold,
                       input bit push, input int ew);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready low for %0d cycles expected high", n);
    end
    if (ew >= 0) chk("ready_low_cycles", 32'(n), 32'(ew));
    if (push) q.push_back('{err: err, rdata: rdata, lat: lat, nwe: nwe, wd: wd, acc: cyc + 1});
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      req_valid = 0;
    end
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                    input logic [31:0] exp, input logic bad, input bit hold, input int ew);
    issue(1'b0, sz, uns, addr, 32'h0, bad, bad ? 32'h0 : exp, bad ? 1 : 2, 0, 32'h0, hold, 1'b1, ew);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] wd, input logic bad, input bit hold, input int ew);
    issue(1'b1, sz, 1'b0, addr, wdata, bad, 32'h0, bad ? 1 : (sz == 2'b10 ? 2 : 3),
          bad ? 0 : 1, wd, hold, 1'b1, ew);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_mem_wd"}, mem_wd, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]  = 32'h11223344;
    mem[15] = 32'hDEADBEEF;
    rst_n = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0;
    #3 chk_reset_outs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Loads from preset word 15 = DEADBEEF
    ld(2'b10, 1'b0, 32'h3C, 32'hDEADBEEF, 1'b0, 1'b0, -1);
    ld(2'b00, 1'b0, 32'h3C, 32'hFFFFFFEF, 1'b0, 1'b0, -1);
    ld(2'b00, 1'b1, 32'h3F, 32'h000000DE, 1'b0, 1'b0, -1);
    ld(2'b01, 1'b0, 32'h3E, 32'hFFFFDEAD, 1'b0, 1'b0, -1);
    ld(2'b01, 1'b1, 32'h3C, 32'h0000BEEF, 1'b0, 1'b0, -1);
    drain();

    // Reset pulsed while a byte store sits in ACCESS
    issue(1'b1, 2'b00, 1'b0, 32'h3C, 32'h00000011, 1'b0, 32'h0, 0, 0, 32'h0, 1'b1, 1'b0, -1);
    #2;
    rst_n = 0;
    req_valid = 0;
    #1 chk_reset_outs("abort");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("abort_we_cycles", 32'(we_cnt), 32'd0);
    chk("abort_word15", mem[15], 32'hDEADBEEF);
    we_cnt = 0;
    ld(2'b10, 1'b0, 32'h3C, 32'hDEADBEEF, 1'b0, 1'b0, -1);

    // Sub-word and word stores followed by readback
    st(2'b01, 32'h3E, 32'h00001234, 32'h1234BEEF, 1'b0, 1'b0, -1);
    ld(2'b10, 1'b0, 32'h3C, 32'h1234BEEF, 1'b0, 1'b0, -1);
    st(2'b10, 32'h10, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, -1);
    ld(2'b00, 1'b0, 32'h11, 32'hFFFFFFF0, 1'b0, 1'b0, -1);
    ld(2'b01, 1'b1, 32'h12, 32'h0000CAFE, 1'b0, 1'b0, -1);

    // Errors: misaligned word, misaligned half store, illegal size, index 64
    ld(2'b10, 1'b0, 32'h3D, 32'h0, 1'b1, 1'b0, -1);
    st(2'b01, 32'h01, 32'h0000BBBB, 32'h0, 1'b1, 1'b0, -1);
    ld(2'b11, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, -1);
    ld(2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, -1);
    drain();

    // Back-to-back with req_valid held: ready must stay low for the full latency
    st(2'b00, 32'h00, 32'h000000AA, 32'h112233AA, 1'b0, 1'b1, -1);
    ld(2'b00, 1'b1, 32'h00, 32'h000000AA, 1'b0, 1'b1, 3);
    st(2'b00, 32'h01, 32'h00000077, 32'h112277AA, 1'b0, 1'b1, 2);
    ld(2'b00, 1'b1, 32'h01, 32'h00000077, 1'b0, 1'b0, 3);
    drain();
    chk("final_word0", mem[0], 32'h112277AA);
    chk("final_word15", mem[15], 32'h1234BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
